ctrl_pipe: RTL and testbench
============================

// Module: ctrl_pipe
// PURPOSE
//  Consumer end of the opcode decoder's control outputs. Carries the decoded control bundle and rd through the ID/EX, EX/MEM and MEM/WB stages.
//  Detects load-use hazards and inserts bubbles. Squashes the ID-stage instruction on a redirect taken in EX.
//  Cleans the decoder's don't-care (x) bits so only 0/1 values enter the pipe.
// PARAMETERS
//  REG_ADDR_W  5   register-index width (rd/rs1/rs2)
//  PERF_CNT_W  32  width of the performance counters (only with CTRL_PIPE_PERF_EN)
// PORTS
//  clk          in   1   single clock, rising edge
//  reset_n      in   1   asynchronous, active-low reset
//  id_valid     in   1   ID holds a real instruction
//  id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite, id_jump  in  1 each  decoder outputs
//  id_aluop     in   2   decoder ALUOp
//  id_rd, id_rs1, id_rs2  in  REG_ADDR_W  ID register indices
//  ex_redirect  in   1   branch taken or jump resolved in EX this cycle
//  hold_if_id   out  1   freeze PC and IF/ID (load-use stall)
//  ex_valid, ex_alusrc, ex_branch, ex_jump, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite  out  1 each
//  ex_aluop     out  2;   ex_rd   out  REG_ADDR_W
//  mem_valid, mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite  out  1 each;  mem_rd  out  REG_ADDR_W
//  wb_valid, wb_memtoreg, wb_regwrite  out  1 each;  wb_rd  out  REG_ADDR_W
//  perf_stalls, perf_flushes  out  PERF_CNT_W  (present only with CTRL_PIPE_PERF_EN)
// BEHAVIOUR
//  Reset (reset_n=0, async): every stage register and every output is 0, including valid, control, rd and ALUOp. hold_if_id=0.
//  Sanitise (combinational, ID side):
//  - If id_valid=0, the bundle is all-zero.
//  - Otherwise, any bit that is not 1'b1 becomes 0. This includes x/z on MemRead, MemWrite and MemtoReg.
//  - If id_jump=1, then memread=0, memwrite=0, memtoreg=1 and regwrite=1.
//  - rd=0 forces regwrite=0.
//  load_use = ex_valid & ex_memread & (ex_rd!=0) & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2).
//  hold_if_id = load_use & ~ex_redirect. This is combinational, same cycle.
//  ID->EX on each clk edge:
//  - If ex_redirect: bubble (all-zero bundle). This takes priority over load_use, because the ID instruction is dead.
//  - Else if load_use: bubble, and ID is held by hold_if_id.
//  - Else: the sanitised ID bundle.
//  EX->MEM and MEM->WB always advance unconditionally. These stages never stall and are never flushed.
//  The redirecting instruction itself proceeds to MEM, so a jal/jalr still writes rd.
//  Latency: ID->EX 1 cycle, ->MEM 2 cycles, ->WB 3 cycles. Throughput is 1 per cycle with no hazard.
//  Bubble: valid=0 and all controls 0, so a bubble never writes memory or the register file.
//  Reset asserted mid-operation clears all stages immediately. The first valid EX appears one edge after release and a valid ID.
// CONFIGURATION
//  CTRL_PIPE_PERF_EN defined:
//  - perf_stalls increments on each edge where load_use & ~ex_redirect.
//  - perf_flushes increments on each edge where ex_redirect & id_valid.
//  - Both counters wrap modulo 2^PERF_CNT_W and are reset to 0.
//  CTRL_PIPE_PERF_EN undefined: the counter ports and their logic are absent. All other behaviour is identical.
// STRUCTURE
//  Package ctrl_pipe_pkg holds:
//  - opcode localparams (R 0110011, LD 0000011, I 0010011, SD 0100011, SB 1100011, JALR 1100111, JAL 1101111);
//  - ALUOp encodings (00 add, 01 branch, 10 R, 11 I);
//  - the ctrl bundle struct (valid, alusrc, aluop, branch, jump, memread, memwrite, memtoreg, regwrite, rd) and CTRL_BUBBLE all-zero constant.
//  Sub-module ctrl_stage_reg:
//  - parameterised stage register with async active-low clear and a bubble_i select;
//  - instantiated three times.
// TESTING
//  1. reset_n=0 mid-stream with a load in EX -> all ex_/mem_/wb_ outputs 0 immediately, hold_if_id=0.
//  2. R-type add (id_regwrite=1, aluop=10, rd=5), then 3 edges -> ex_aluop=10 at +1, mem_regwrite=1 at +2, wb_regwrite=1 with wb_rd=5 at +3.
//  3. ld x6 in EX, ID add with rs1=6 -> hold_if_id=1 for exactly 1 cycle, one bubble in EX (ex_valid=0), then add enters EX. perf_stalls=1 with macro.
//  4. ld x0 in EX, ID rs1=0 -> no stall, hold_if_id=0.
//  5. ex_redirect=1 while load_use=1 -> hold_if_id=0, EX bubble next edge, the redirecting jal reaches MEM with mem_regwrite=1. perf_flushes=1 with macro.
//  6. jal with decoder MemRead/MemWrite=x -> ex_memread=0 and ex_memwrite=0, ex_memtoreg=1, with no x on any output.

Source files
------------

// File: rtl/ctrl_pipe_pkg.sv
// Shared types for the control pipe: opcodes, ALUOp encodings and the per-stage
// control bundles that travel ID/EX -> EX/MEM -> MEM/WB.
package ctrl_pipe_pkg;

    localparam int RD_W = 5;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_SD   = 7'b0100011;
    localparam logic [6:0] OP_SB   = 7'b1100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    typedef struct packed {
        logic            valid;
        logic            alusrc;
        logic [1:0]      aluop;
        logic            branch;
        logic            jump;
        logic            memread;
        logic            memwrite;
        logic            memtoreg;
        logic            regwrite;
        logic [RD_W-1:0] rd;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // Later stages only carry the fields they still consume.
    typedef struct packed {
        logic            valid;
        logic            memread;
        logic            memwrite;
        logic            memtoreg;
        logic            regwrite;
        logic [RD_W-1:0] rd;
    } mem_ctrl_t;

    typedef struct packed {
        logic            valid;
        logic            memtoreg;
        logic            regwrite;
        logic [RD_W-1:0] rd;
    } wb_ctrl_t;

    // Only a definite 1 counts; x/z from the decoder's don't-care rows become 0.
    function automatic logic is_one(input logic b);
        return (b === 1'b1);
    endfunction

endpackage

// File: rtl/ctrl_pipe_stage_reg.sv
// Generic pipeline stage register: async active-low clear, synchronous bubble
// select that loads an all-zero bundle instead of d_i.
module ctrl_stage_reg
    import ctrl_pipe_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         bubble_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    assign data_d = bubble_i ? '0 : d_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) data_q <= '0;
        else         data_q <= data_d;
    end

    assign q_o = data_q;

endmodule

// File: rtl/ctrl_pipe.sv
// Control pipe ID->EX->MEM->WB with load-use stall and EX-redirect squash.
// Optional performance counters are built when CTRL_PIPE_PERF_EN is defined.
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int REG_ADDR_W = RD_W
`ifdef CTRL_PIPE_PERF_EN
    , parameter int PERF_CNT_W = 32
`endif
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  id_valid,
    input  logic                  id_branch,
    input  logic                  id_memread,
    input  logic                  id_memtoreg,
    input  logic                  id_memwrite,
    input  logic                  id_alusrc,
    input  logic                  id_regwrite,
    input  logic                  id_jump,
    input  logic [1:0]            id_aluop,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  ex_redirect,
    output logic                  hold_if_id,
    output logic                  ex_valid,
    output logic                  ex_alusrc,
    output logic                  ex_branch,
    output logic                  ex_jump,
    output logic                  ex_memread,
    output logic                  ex_memwrite,
    output logic                  ex_memtoreg,
    output logic                  ex_regwrite,
    output logic [1:0]            ex_aluop,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  mem_valid,
    output logic                  mem_memread,
    output logic                  mem_memwrite,
    output logic                  mem_memtoreg,
    output logic                  mem_regwrite,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  wb_valid,
    output logic                  wb_memtoreg,
    output logic                  wb_regwrite,
    output logic [REG_ADDR_W-1:0] wb_rd
`ifdef CTRL_PIPE_PERF_EN
    , output logic [PERF_CNT_W-1:0] perf_stalls
    , output logic [PERF_CNT_W-1:0] perf_flushes
`endif
);

    ctrl_t     id_c, ex_q;
    mem_ctrl_t mem_d, mem_q;
    wb_ctrl_t  wb_d, wb_q;
    logic      load_use;
    logic      id_ex_bubble;

    always_comb begin
        id_c = CTRL_BUBBLE;
        if (id_valid) begin
            id_c.valid    = 1'b1;
            id_c.alusrc   = is_one(id_alusrc);
            id_c.aluop    = {is_one(id_aluop[1]), is_one(id_aluop[0])};
            id_c.branch   = is_one(id_branch);
            id_c.jump     = is_one(id_jump);
            id_c.memread  = is_one(id_memread);
            id_c.memwrite = is_one(id_memwrite);
            id_c.memtoreg = is_one(id_memtoreg);
            id_c.regwrite = is_one(id_regwrite);
            id_c.rd       = id_rd;
            // Jumps write the link address: never touch memory, always write rd.
            if (id_c.jump) begin
                id_c.memread  = 1'b0;
                id_c.memwrite = 1'b0;
                id_c.memtoreg = 1'b1;
                id_c.regwrite = 1'b1;
            end
            if (id_rd == '0) id_c.regwrite = 1'b0;
        end
    end

    assign load_use = ex_q.valid & ex_q.memread & (ex_q.rd != '0) & id_valid &
                      ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));

    // A redirect kills the ID instruction, so there is nothing left to hold.
    assign hold_if_id   = load_use & ~ex_redirect;
    assign id_ex_bubble = ex_redirect | load_use;

    assign mem_d = '{valid:    ex_q.valid,
                     memread:  ex_q.memread,
                     memwrite: ex_q.memwrite,
                     memtoreg: ex_q.memtoreg,
                     regwrite: ex_q.regwrite,
                     rd:       ex_q.rd};

    assign wb_d = '{valid:    mem_q.valid,
                    memtoreg: mem_q.memtoreg,
                    regwrite: mem_q.regwrite,
                    rd:       mem_q.rd};

    ctrl_stage_reg #(.W($bits(ctrl_t))) u_id_ex (
        .clk_i    (clk),
        .rst_ni   (reset_n),
        .bubble_i (id_ex_bubble),
        .d_i      (id_c),
        .q_o      (ex_q)
    );

    ctrl_stage_reg #(.W($bits(mem_ctrl_t))) u_ex_mem (
        .clk_i    (clk),
        .rst_ni   (reset_n),
        .bubble_i (1'b0),
        .d_i      (mem_d),
        .q_o      (mem_q)
    );

    ctrl_stage_reg #(.W($bits(wb_ctrl_t))) u_mem_wb (
        .clk_i    (clk),
        .rst_ni   (reset_n),
        .bubble_i (1'b0),
        .d_i      (wb_d),
        .q_o      (wb_q)
    );

    assign ex_valid     = ex_q.valid;
    assign ex_alusrc    = ex_q.alusrc;
    assign ex_aluop     = ex_q.aluop;
    assign ex_branch    = ex_q.branch;
    assign ex_jump      = ex_q.jump;
    assign ex_memread   = ex_q.memread;
    assign ex_memwrite  = ex_q.memwrite;
    assign ex_memtoreg  = ex_q.memtoreg;
    assign ex_regwrite  = ex_q.regwrite;
    assign ex_rd        = ex_q.rd;

    assign mem_valid    = mem_q.valid;
    assign mem_memread  = mem_q.memread;
    assign mem_memwrite = mem_q.memwrite;
    assign mem_memtoreg = mem_q.memtoreg;
    assign mem_regwrite = mem_q.regwrite;
    assign mem_rd       = mem_q.rd;

    assign wb_valid     = wb_q.valid;
    assign wb_memtoreg  = wb_q.memtoreg;
    assign wb_regwrite  = wb_q.regwrite;
    assign wb_rd        = wb_q.rd;

`ifdef CTRL_PIPE_PERF_EN
    logic [PERF_CNT_W-1:0] stalls_q, stalls_d;
    logic [PERF_CNT_W-1:0] flushes_q, flushes_d;

    // Counters wrap naturally at 2^PERF_CNT_W.
    assign stalls_d  = hold_if_id               ? stalls_q  + PERF_CNT_W'(1) : stalls_q;
    assign flushes_d = (ex_redirect & id_valid) ? flushes_q + PERF_CNT_W'(1) : flushes_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stalls_q  <= '0;
            flushes_q <= '0;
        end else begin
            stalls_q  <= stalls_d;
            flushes_q <= flushes_d;
        end
    end

    assign perf_stalls  = stalls_q;
    assign perf_flushes = flushes_q;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: expected stage bundles are queued with the
// cycle they are due and popped/compared at the falling edge of that cycle.
module tb_ctrl_pipe;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       id_valid, id_branch, id_memread, id_memtoreg, id_memwrite;
    logic       id_alusrc, id_regwrite, id_jump;
    logic [1:0] id_aluop;
    logic [4:0] id_rd, id_rs1, id_rs2;
    logic       ex_redirect;
    logic       hold_if_id;
    logic       ex_valid, ex_alusrc, ex_branch, ex_jump, ex_memread, ex_memwrite;
    logic       ex_memtoreg, ex_regwrite;
    logic [1:0] ex_aluop;
    logic [4:0] ex_rd;
    logic       mem_valid, mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite;
    logic [4:0] mem_rd;
    logic       wb_valid, wb_memtoreg, wb_regwrite;
    logic [4:0] wb_rd;
`ifdef CTRL_PIPE_PERF_EN
    logic [31:0] perf_stalls, perf_flushes;
`endif

    ctrl_pipe dut (
        .clk(clk), .reset_n(reset_n),
        .id_valid(id_valid), .id_branch(id_branch), .id_memread(id_memread),
        .id_memtoreg(id_memtoreg), .id_memwrite(id_memwrite), .id_alusrc(id_alusrc),
        .id_regwrite(id_regwrite), .id_jump(id_jump), .id_aluop(id_aluop),
        .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_redirect(ex_redirect),
        .hold_if_id(hold_if_id),
        .ex_valid(ex_valid), .ex_alusrc(ex_alusrc), .ex_branch(ex_branch), .ex_jump(ex_jump),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
        .ex_regwrite(ex_regwrite), .ex_aluop(ex_aluop), .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .mem_memtoreg(mem_memtoreg), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
        .wb_valid(wb_valid), .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd)
`ifdef CTRL_PIPE_PERF_EN
        , .perf_stalls(perf_stalls), .perf_flushes(perf_flushes)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        int          stg;   // 0 EX, 1 MEM, 2 WB
        logic [15:0] val;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [15:0] obs;
    int          n_vec = 0;
    int          n_err = 0;
    int          c0;

    function automatic logic [15:0] exv(input logic v, input logic as, input logic [1:0] op,
                                        input logic br, input logic j, input logic mr,
                                        input logic mw, input logic mt, input logic rw,
                                        input logic [4:0] rd);
        return {1'b0, v, as, op, br, j, mr, mw, mt, rw, rd};
    endfunction

    function automatic logic [15:0] memv(input logic v, input logic mr, input logic mw,
                                         input logic mt, input logic rw, input logic [4:0] rd);
        return {6'b0, v, mr, mw, mt, rw, rd};
    endfunction

    function automatic logic [15:0] wbv(input logic v, input logic mt, input logic rw,
                                        input logic [4:0] rd);
        return {8'b0, v, mt, rw, rd};
    endfunction

    function automatic logic [15:0] ex_obs();
        return {1'b0, ex_valid, ex_alusrc, ex_aluop, ex_branch, ex_jump, ex_memread,
                ex_memwrite, ex_memtoreg, ex_regwrite, ex_rd};
    endfunction

    function automatic logic [15:0] mem_obs();
        return {6'b0, mem_valid, mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite, mem_rd};
    endfunction

    function automatic logic [15:0] wb_obs();
        return {8'b0, wb_valid, wb_memtoreg, wb_regwrite, wb_rd};
    endfunction

    task automatic push(input int due, input int stg, input logic [15:0] val, input string name);
        exp_t x;
        x.due = due; x.stg = stg; x.val = val; x.name = name;
        sb.push_back(x);
    endtask

    // Argument order: valid, alusrc, aluop, branch, jump, memread, memwrite, memtoreg, regwrite, rd, rs1, rs2
    task automatic set_id(input logic v, input logic as, input logic [1:0] op, input logic br,
                          input logic j, input logic mr, input logic mw, input logic mt,
                          input logic rw, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2);
        id_valid = v; id_alusrc = as; id_aluop = op; id_branch = br; id_jump = j;
        id_memread = mr; id_memwrite = mw; id_memtoreg = mt; id_regwrite = rw;
        id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    endtask

    task automatic id_idle();
        set_id(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic test_reset();
        n_vec++; if (ex_obs() !== 16'h0) begin n_err++; $display("FAIL reset_ex: got %h expected 0000", ex_obs()); end
        n_vec++; if (mem_obs() !== 16'h0) begin n_err++; $display("FAIL reset_mem: got %h expected 0000", mem_obs()); end
        n_vec++; if (wb_obs() !== 16'h0) begin n_err++; $display("FAIL reset_wb: got %h expected 0000", wb_obs()); end
        n_vec++; if (hold_if_id !== 1'b0) begin n_err++; $display("FAIL reset_hold: got %b expected 0", hold_if_id); end
    endtask

    task automatic test_reset_midstream();
        set_id(1, 1, 2'b00, 0, 0, 1, 0, 1, 1, 5'd6, 5'd2, 5'd0);   // ld x6
        @(posedge clk); @(negedge clk);
        set_id(1, 0, 2'b10, 0, 0, 0, 0, 0, 1, 5'd7, 5'd6, 5'd3);   // add x7,x6,x3
        #1;
        n_vec++; if ({ex_valid, ex_memread} !== 2'b11) begin n_err++; $display("FAIL rstmid_pre_ex: got %b expected 11", {ex_valid, ex_memread}); end
        n_vec++; if (hold_if_id !== 1'b1) begin n_err++; $display("FAIL rstmid_pre_hold: got %b expected 1", hold_if_id); end
        reset_n = 1'b0;
        #1;
        n_vec++; if (ex_obs() !== 16'h0) begin n_err++; $display("FAIL rstmid_ex: got %h expected 0000", ex_obs()); end
        n_vec++; if (mem_obs() !== 16'h0) begin n_err++; $display("FAIL rstmid_mem: got %h expected 0000", mem_obs()); end
        n_vec++; if (wb_obs() !== 16'h0) begin n_err++; $display("FAIL rstmid_wb: got %h expected 0000", wb_obs()); end
        n_vec++; if (hold_if_id !== 1'b0) begin n_err++; $display("FAIL rstmid_hold: got %b expected 0", hold_if_id); end
        @(posedge clk); @(negedge clk);
        reset_n = 1'b1;
        push(cyc + 1, 0, exv(1, 0, 2'b10, 0, 0, 0, 0, 0, 1, 5'd7), "rstmid_first_ex");
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); @(negedge clk);
            while (sb.size() != 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                obs = (e.stg == 0) ? ex_obs() : (e.stg == 1) ? mem_obs() : wb_obs();
                n_vec++;
                if (obs !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
            end
            id_idle();
        end
    endtask

    task automatic test_rtype();
        c0 = cyc;
        push(c0 + 1, 0, exv(1, 0, 2'b10, 0, 0, 0, 0, 0, 1, 5'd5), "rtype_ex");
        push(c0 + 2, 0, 16'h0, "rtype_ex_after");
        push(c0 + 2, 1, memv(1, 0, 0, 0, 1, 5'd5), "rtype_mem");
        push(c0 + 3, 2, wbv(1, 0, 1, 5'd5), "rtype_wb");
        set_id(1, 0, 2'b10, 0, 0, 0, 0, 0, 1, 5'd5, 5'd1, 5'd2);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); @(negedge clk);
            id_idle();
            while (sb.size() != 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                obs = (e.stg == 0) ? ex_obs() : (e.stg == 1) ? mem_obs() : wb_obs();
                n_vec++;
                if (obs !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
            end
        end
    endtask

    task automatic test_load_use();
        c0 = cyc;
        push(c0 + 1, 0, exv(1, 1, 2'b00, 0, 0, 1, 0, 1, 1, 5'd6), "lu_ex_ld");
        push(c0 + 2, 0, 16'h0, "lu_ex_bubble");
        push(c0 + 2, 1, memv(1, 1, 0, 1, 1, 5'd6), "lu_mem_ld");
        push(c0 + 3, 0, exv(1, 0, 2'b10, 0, 0, 0, 0, 0, 1, 5'd7), "lu_ex_add");
        push(c0 + 3, 1, 16'h0, "lu_mem_bubble");
        push(c0 + 3, 2, wbv(1, 1, 1, 5'd6), "lu_wb_ld");
        push(c0 + 4, 1, memv(1, 0, 0, 0, 1, 5'd7), "lu_mem_add");
        push(c0 + 5, 2, wbv(1, 0, 1, 5'd7), "lu_wb_add");
        set_id(1, 1, 2'b00, 0, 0, 1, 0, 1, 1, 5'd6, 5'd2, 5'd0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); @(negedge clk);
            while (sb.size() != 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                obs = (e.stg == 0) ? ex_obs() : (e.stg == 1) ? mem_obs() : wb_obs();
                n_vec++;
                if (obs !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
            end
            if (k == 0) begin
                set_id(1, 0, 2'b10, 0, 0, 0, 0, 0, 1, 5'd7, 5'd6, 5'd3);
                #1;
                n_vec++; if (hold_if_id !== 1'b1) begin n_err++; $display("FAIL lu_hold_on: got %b expected 1", hold_if_id); end
            end else if (k == 1) begin
                #1;
                n_vec++; if (hold_if_id !== 1'b0) begin n_err++; $display("FAIL lu_hold_off: got %b expected 0", hold_if_id); end
            end else begin
                id_idle();
            end
        end
`ifdef CTRL_PIPE_PERF_EN
        n_vec++; if (perf_stalls !== 32'd1) begin n_err++; $display("FAIL lu_perf_stalls: got %0d expected 1", perf_stalls); end
`endif
    endtask

    task automatic test_load_x0();
        c0 = cyc;
        push(c0 + 1, 0, exv(1, 1, 2'b00, 0, 0, 1, 0, 1, 0, 5'd0), "x0_ex_ld");
        push(c0 + 2, 0, exv(1, 0, 2'b10, 0, 0, 0, 0, 0, 1, 5'd8), "x0_ex_add");
        push(c0 + 2, 1, memv(1, 1, 0, 1, 0, 5'd0), "x0_mem_ld");
        push(c0 + 3, 1, memv(1, 0, 0, 0, 1, 5'd8), "x0_mem_add");
        push(c0 + 3, 2, wbv(1, 1, 0, 5'd0), "x0_wb_ld");
        set_id(1, 1, 2'b00, 0, 0, 1, 0, 1, 1, 5'd0, 5'd3, 5'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); @(negedge clk);
            while (sb.size() != 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                obs = (e.stg == 0) ? ex_obs() : (e.stg == 1) ? mem_obs() : wb_obs();
                n_vec++;
                if (obs !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
            end
            if (k == 0) begin
                set_id(1, 0, 2'b10, 0, 0, 0, 0, 0, 1, 5'd8, 5'd0, 5'd0);
                #1;
                n_vec++; if (hold_if_id !== 1'b0) begin n_err++; $display("FAIL x0_hold: got %b expected 0", hold_if_id); end
            end else begin
                id_idle();
            end
        end
    endtask

    task automatic test_redirect();
        c0 = cyc;
        push(c0 + 1, 0, exv(1, 1, 2'b00, 0, 0, 1, 0, 1, 1, 5'd6), "rd_ex_ld");
        push(c0 + 2, 0, 16'h0, "rd_ex_bubble1");
        push(c0 + 2, 1, memv(1, 1, 0, 1, 1, 5'd6), "rd_mem_ld");
        push(c0 + 3, 0, exv(1, 0, 2'b00, 0, 1, 0, 0, 1, 1, 5'd1), "rd_ex_jal");
        push(c0 + 4, 0, 16'h0, "rd_ex_bubble2");
        push(c0 + 4, 1, memv(1, 0, 0, 1, 1, 5'd1), "rd_mem_jal");
        push(c0 + 5, 2, wbv(1, 1, 1, 5'd1), "rd_wb_jal");
        set_id(1, 1, 2'b00, 0, 0, 1, 0, 1, 1, 5'd6, 5'd2, 5'd0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); @(negedge clk);
            while (sb.size() != 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                obs = (e.stg == 0) ? ex_obs() : (e.stg == 1) ? mem_obs() : wb_obs();
                n_vec++;
                if (obs !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
            end
            case (k)
                0: begin
                    set_id(1, 0, 2'b10, 0, 0, 0, 0, 0, 1, 5'd7, 5'd6, 5'd3);
                    ex_redirect = 1'b1;
                    #1;
                    n_vec++; if (hold_if_id !== 1'b0) begin n_err++; $display("FAIL rd_hold: got %b expected 0", hold_if_id); end
                end
                1: begin
                    ex_redirect = 1'b0;
                    set_id(1, 0, 2'b00, 0, 1, 0, 0, 1, 1, 5'd1, 5'd0, 5'd0);   // jal x1
`ifdef CTRL_PIPE_PERF_EN
                    n_vec++; if (perf_flushes !== 32'd1) begin n_err++; $display("FAIL rd_perf_flushes1: got %0d expected 1", perf_flushes); end
`endif
                end
                2: begin
                    set_id(1, 0, 2'b10, 0, 0, 0, 0, 0, 1, 5'd4, 5'd9, 5'd10);
                    ex_redirect = 1'b1;
                end
                default: begin
                    ex_redirect = 1'b0;
                    id_idle();
                end
            endcase
        end
`ifdef CTRL_PIPE_PERF_EN
        n_vec++; if (perf_flushes !== 32'd2) begin n_err++; $display("FAIL rd_perf_flushes2: got %0d expected 2", perf_flushes); end
        n_vec++; if (perf_stalls !== 32'd1) begin n_err++; $display("FAIL rd_perf_stalls: got %0d expected 1", perf_stalls); end
`endif
    endtask

    task automatic test_back_to_back();
        c0 = cyc;
        for (int d = 1; d <= 5; d++)
            for (int s = 0; s < 3; s++) begin
                int i;
                i = d - 1 - s;
                if (i >= 0 && i < 3)
                    push(c0 + d, s,
                         (s == 0) ? exv(1, 0, 2'b10, 0, 0, 0, 0, 0, 1, 5'(9 + i)) :
                         (s == 1) ? memv(1, 0, 0, 0, 1, 5'(9 + i)) : wbv(1, 0, 1, 5'(9 + i)),
                         $sformatf("b2b_s%0d_i%0d", s, i));
            end
        set_id(1, 0, 2'b10, 0, 0, 0, 0, 0, 1, 5'd9, 5'd1, 5'd2);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); @(negedge clk);
            while (sb.size() != 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                obs = (e.stg == 0) ? ex_obs() : (e.stg == 1) ? mem_obs() : wb_obs();
                n_vec++;
                if (obs !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
            end
            if (k < 2) set_id(1, 0, 2'b10, 0, 0, 0, 0, 0, 1, 5'(10 + k), 5'd1, 5'd2);
            else       id_idle();
        end
    endtask

    task automatic test_jump_sanitise();
        c0 = cyc;
        push(c0 + 1, 0, exv(1, 0, 2'b00, 0, 1, 0, 0, 1, 1, 5'd1), "jmp_ex_x");
        push(c0 + 2, 0, exv(1, 0, 2'b00, 0, 1, 0, 0, 1, 0, 5'd0), "jmp_ex_x0");
        push(c0 + 2, 1, memv(1, 0, 0, 1, 1, 5'd1), "jmp_mem_x");
        set_id(1, 0, 2'b00, 0, 1, 1'bx, 1'bx, 1'bx, 1'bx, 5'd1, 5'd0, 5'd0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); @(negedge clk);
            while (sb.size() != 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                obs = (e.stg == 0) ? ex_obs() : (e.stg == 1) ? mem_obs() : wb_obs();
                n_vec++;
                if (obs !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
            end
            if (k == 0) begin
                n_vec++;
                if ($isunknown({ex_obs(), mem_obs(), wb_obs(), hold_if_id})) begin
                    n_err++; $display("FAIL jmp_no_x: got ex=%h mem=%h wb=%h expected no x", ex_obs(), mem_obs(), wb_obs());
                end
                set_id(1, 0, 2'b00, 0, 1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);   // jal x0
            end else begin
                id_idle();
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        ex_redirect = 1'b0;
        set_id(1, 0, 2'b10, 0, 0, 0, 0, 0, 1, 5'd3, 5'd1, 5'd2);
        repeat (2) @(negedge clk);
        test_reset();
        id_idle();
        reset_n = 1'b1;
        @(negedge clk);
        test_reset_midstream();
        test_rtype();
        test_load_use();
        test_load_x0();
        test_redirect();
        test_back_to_back();
        test_jump_sanitise();
        while (sb.size() != 0) begin
            e = sb.pop_front();
            n_vec++; n_err++;
            $display("FAIL %s: got never-checked expected %h at cycle %0d", e.name, e.val, e.due);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
